// File: rtl/data_mem_controller.sv
// Multi-channel arbiter between per-thread LSU load/store ports and data memory.
// Each channel claims one consumer, runs one memory transaction, then relays the response back.
module data_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  // state          | meaning
  // IDLE           | free, arbitrating among unclaimed requesters
  // READ_WAITING   | memory read issued, waiting for mem_read_ready
  // WRITE_WAITING  | memory write issued, waiting for mem_write_ready
  // READ_RELAYING  | read ready/data held until consumer drops read valid
  // WRITE_RELAYING | write ready held until consumer drops write valid
  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  state_t        state   [NUM_CHANNELS];
  state_t        state_n [NUM_CHANNELS];
  logic [IW-1:0] idx     [NUM_CHANNELS];
  logic [IW-1:0] idx_n   [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0] claimed, claimed_n, taken;
  logic                     found;
  logic [IW-1:0]            pick;

  logic [NUM_CONSUMERS-1:0]                 crr_n, cwr_n;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  crd_n;
  logic [NUM_CHANNELS-1:0]                  mrv_n, mwv_n;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mra_n, mwa_n;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mwd_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state[c] <= IDLE;
        idx[c]   <= '0;
      end
      claimed              <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state[c] <= state_n[c];
        idx[c]   <= idx_n[c];
      end
      claimed              <= claimed_n;
      consumer_read_ready  <= crr_n;
      consumer_read_data   <= crd_n;
      consumer_write_ready <= cwr_n;
      mem_read_valid       <= mrv_n;
      mem_read_address     <= mra_n;
      mem_write_valid      <= mwv_n;
      mem_write_address    <= mwa_n;
      mem_write_data       <= mwd_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    claimed_n = claimed;
    taken     = claimed;
    found     = 1'b0;
    pick      = '0;
    crr_n     = consumer_read_ready;
    crd_n     = consumer_read_data;
    cwr_n     = consumer_write_ready;
    mrv_n     = mem_read_valid;
    mra_n     = mem_read_address;
    mwv_n     = mem_write_valid;
    mwa_n     = mem_write_address;
    mwd_n     = mem_write_data;

    // Channels resolve in ascending order; taken carries this cycle's picks upward.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      pick  = '0;
      case (state[c])
        IDLE: begin
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && (consumer_read_valid[i] || consumer_write_valid[i]) && !taken[i]) begin
              found = 1'b1;
              pick  = IW'(i);
            end
          end
          if (found) begin
            taken[pick]     = 1'b1;
            claimed_n[pick] = 1'b1;
            idx_n[c]        = pick;
            if (consumer_read_valid[pick]) begin
              mrv_n[c]   = 1'b1;
              mra_n[c]   = consumer_read_address[pick];
              state_n[c] = READ_WAITING;
            end else begin
              mwv_n[c]   = 1'b1;
              mwa_n[c]   = consumer_write_address[pick];
              mwd_n[c]   = consumer_write_data[pick];
              state_n[c] = WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            mrv_n[c]       = 1'b0;
            crr_n[idx[c]]  = 1'b1;
            crd_n[idx[c]]  = mem_read_data[c];
            state_n[c]     = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            mwv_n[c]      = 1'b0;
            cwr_n[idx[c]] = 1'b1;
            state_n[c]    = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[idx[c]]) begin
            crr_n[idx[c]]     = 1'b0;
            claimed_n[idx[c]] = 1'b0;
            state_n[c]        = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[idx[c]]) begin
            cwr_n[idx[c]]     = 1'b0;
            claimed_n[idx[c]] = 1'b0;
            state_n[c]        = IDLE;
          end
        end
        default: state_n[c] = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench: a single-channel instance with a small memory model, and a
// two-channel instance driven by hand for parallel writes.
module tb_data_mem_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // single-channel instance
  logic [3:0]       a_crv, a_cwv, a_crr, a_cwr;
  logic [3:0][7:0]  a_cra, a_cwa, a_cwd, a_crd;
  logic [0:0]       a_mrv, a_mwv, a_mrr, a_mwr;
  logic [0:0][7:0]  a_mra, a_mrd, a_mwa, a_mwd;

  data_mem_controller #(.NUM_CHANNELS(1)) u_a (
    .clk(clk), .reset(rst_n),
    .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
    .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  // two-channel instance
  logic [3:0]       b_crv, b_cwv, b_crr, b_cwr;
  logic [3:0][7:0]  b_cra, b_cwa, b_cwd, b_crd;
  logic [1:0]       b_mrv, b_mwv, b_mrr, b_mwr;
  logic [1:0][7:0]  b_mra, b_mrd, b_mwa, b_mwd;

  data_mem_controller #(.NUM_CHANNELS(2)) u_b (
    .clk(clk), .reset(rst_n),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  // memory model for instance A; mem_auto=0 hands the read port to the bench
  logic [7:0] mem_arr [256];
  int         rd_delay = 0;
  int         rcnt = 0;
  logic       mem_auto = 1'b1;
  logic       auto_rr = 1'b0, man_rr = 1'b0;
  logic [7:0] auto_rd = '0, man_rd = '0;
  logic       auto_wr = 1'b0;

  assign a_mrr[0] = mem_auto ? auto_rr : man_rr;
  assign a_mrd[0] = mem_auto ? auto_rd : man_rd;
  assign a_mwr[0] = auto_wr;

  always @(negedge clk) begin
    if (!a_mrv[0]) begin
      rcnt    = 0;
      auto_rr = 1'b0;
    end else if (rcnt >= rd_delay) begin
      auto_rr = 1'b1;
      auto_rd = mem_arr[a_mra[0]];
    end else begin
      rcnt++;
    end
    auto_wr = a_mwv[0];
    if (a_mwv[0]) mem_arr[a_mwa[0]] = a_mwd[0];
  end

  task automatic wait_ready(input bit is_write, input int i, input int budget, output int n);
    n = 0;
    while (!(is_write ? a_cwr[i] : a_crr[i]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("wait_timeout", 32'(n), 32'(budget - 1));
  endtask

  int n;
  logic [7:0] exp_addr [3];
  logic [7:0] exp_data [3];
  int         exp_idx  [3];

  initial begin
    for (int k = 0; k < 256; k++) mem_arr[k] = 8'(k);
    a_crv = '0; a_cwv = '0; a_cra = '0; a_cwa = '0; a_cwd = '0;
    b_crv = '0; b_cwv = '0; b_cra = '0; b_cwa = '0; b_cwd = '0;
    b_mrr = '0; b_mrd = '0; b_mwr = '0;
    mem_arr[8'h10] = 8'h5A;

    repeat (2) @(negedge clk);
    check("rst_a_out", 32'({a_crr, a_cwr, a_mrv, a_mwv, a_crd}), 32'd0);
    check("rst_b_out", 32'({b_crr, b_cwr, b_mrv, b_mwv}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single read, memory answers after two extra cycles
    rd_delay = 2;
    a_cra[2] = 8'h10; a_crv[2] = 1'b1;
    @(negedge clk);
    check("t1_mrv", 32'(a_mrv), 32'd1);
    check("t1_mra", 32'(a_mra[0]), 32'h10);
    check("t1_crr_early", 32'(a_crr), 32'd0);
    wait_ready(1'b0, 2, 10, n);
    check("t1_lat", 32'(n), 32'd3);
    check("t1_crd", 32'(a_crd[2]), 32'h5A);
    check("t1_mrv_drop", 32'(a_mrv), 32'd0);
    @(negedge clk);
    check("t1_hold", 32'(a_crr), 32'b0100);
    a_crv[2] = 1'b0;
    @(negedge clk);
    check("t1_crr_drop", 32'(a_crr), 32'd0);
    check("t1_crd_keep", 32'(a_crd[2]), 32'h5A);

    // three simultaneous reads served in index order
    rd_delay = 0;
    mem_arr[8'h30] = 8'hA0; mem_arr[8'h31] = 8'hA1; mem_arr[8'h33] = 8'hA3;
    exp_idx[0] = 0; exp_addr[0] = 8'h30; exp_data[0] = 8'hA0;
    exp_idx[1] = 1; exp_addr[1] = 8'h31; exp_data[1] = 8'hA1;
    exp_idx[2] = 3; exp_addr[2] = 8'h33; exp_data[2] = 8'hA3;
    for (int k = 0; k < 3; k++) a_cra[exp_idx[k]] = exp_addr[k];
    a_crv = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (a_crr == 4'b0000 && n < 20) begin
        @(negedge clk);
        n++;
        if (a_mrv[0]) check("t2_mra", 32'(a_mra[0]), 32'(exp_addr[k]));
      end
      if (n >= 20) check("t2_timeout", 32'(n), 32'd19);
      check("t2_order", 32'(a_crr), 32'(4'b0001 << exp_idx[k]));
      check("t2_data", 32'(a_crd[exp_idx[k]]), 32'(exp_data[k]));
      a_crv[exp_idx[k]] = 1'b0;
      @(negedge clk);
    end
    check("t2_idle", 32'({a_crr, a_mrv}), 32'd0);

    // read and write together: read first, write after re-presentation
    mem_arr[8'h40] = 8'h77;
    a_cra[0] = 8'h40; a_cwa[0] = 8'h41; a_cwd[0] = 8'h99;
    a_crv[0] = 1'b1; a_cwv[0] = 1'b1;
    @(negedge clk);
    check("t4_rd_first", 32'({a_mrv, a_mwv}), 32'b10);
    wait_ready(1'b0, 0, 10, n);
    check("t4_crd", 32'(a_crd[0]), 32'h77);
    check("t4_cwr_none", 32'(a_cwr), 32'd0);
    a_crv[0] = 1'b0;
    @(negedge clk);
    check("t4_crr_drop", 32'(a_crr), 32'd0);
    @(negedge clk);
    check("t4_mw", 32'({a_mwv, a_mwa[0], a_mwd[0]}), {15'd0, 1'b1, 8'h41, 8'h99});
    wait_ready(1'b1, 0, 10, n);
    check("t4_cwr", 32'(a_cwr), 32'b0001);
    check("t4_mem", 32'(mem_arr[8'h41]), 32'h99);
    a_cwv[0] = 1'b0;
    @(negedge clk);
    check("t4_cwr_drop", 32'(a_cwr), 32'd0);

    // memory stalls; request must stay stable and others must wait
    rd_delay = 20;
    mem_arr[8'h50] = 8'h3C; mem_arr[8'h52] = 8'hC3;
    a_cra[1] = 8'h50; a_cra[2] = 8'h52;
    a_crv = 4'b0110;
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      check("t6_stable", 32'({a_mrv, a_mra[0], a_crr}), {19'd0, 1'b1, 8'h50, 4'b0000});
      @(negedge clk);
    end
    wait_ready(1'b0, 1, 10, n);
    check("t6_first", 32'({a_crr, a_crd[1]}), {20'd0, 4'b0010, 8'h3C});
    a_crv[1] = 1'b0;
    wait_ready(1'b0, 2, 40, n);
    check("t6_second", 32'({a_crr, a_crd[2]}), {20'd0, 4'b0100, 8'hC3});
    a_crv[2] = 1'b0;
    @(negedge clk);

    // two channels take consumers 1 and 3 in the same cycle
    b_cwa[1] = 8'h20; b_cwd[1] = 8'h11;
    b_cwa[3] = 8'h21; b_cwd[3] = 8'h22;
    b_cwv = 4'b1010;
    @(negedge clk);
    check("t3_mwv", 32'(b_mwv), 32'b11);
    check("t3_ch0", 32'({b_mwa[0], b_mwd[0]}), 32'h2011);
    check("t3_ch1", 32'({b_mwa[1], b_mwd[1]}), 32'h2122);
    check("t3_cwr_early", 32'(b_cwr), 32'd0);
    b_mwr = 2'b11;
    @(negedge clk);
    b_mwr = 2'b00;
    check("t3_cwr", 32'(b_cwr), 32'b1010);
    check("t3_mwv_drop", 32'(b_mwv), 32'd0);
    b_cwv = 4'b0000;
    @(negedge clk);
    check("t3_cwr_drop", 32'(b_cwr), 32'd0);

    // reset during READ_WAITING; a late memory ready must not reach the consumer
    mem_auto = 1'b0;
    rd_delay = 100;
    a_cra[3] = 8'h60; a_crv[3] = 1'b1;
    @(negedge clk);
    check("t5_waiting", 32'(a_mrv), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async", 32'({a_crr, a_cwr, a_mrv, a_mwv, a_mra[0], a_crd}), 32'd0);
    a_crv[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    man_rr = 1'b1; man_rd = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_ready", 32'({a_crr, a_mrv, a_crd[3]}), 32'd0);
    end
    man_rr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
